// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: word sizes, the
// queue entry layout and small PC helpers used by every fetch file.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t NOP_INSTR        = 32'h0000_0013;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  // One queue entry: the fetch address and the instruction word found there.
  typedef struct packed {
    word_t pc;
    word_t ir;
  } fetch_entry_t;

  // Sequential successor of a PC; wraps modulo 2^XLEN.
  function automatic word_t pc_next(input word_t pc);
    return pc + word_t'(INSTR_BYTES);
  endfunction

  // Force a redirect target onto an instruction boundary.
  function automatic word_t align_pc(input word_t pc);
    return pc & ~word_t'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory, EX (redirects)
// and ID (dequeue). master = the fetch queue, slave = its surroundings.
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH + 1);

  // Instruction memory side
  word_t          imem_addr;
  word_t          imem_data;
  logic           imem_ack_n;

  // Control-flow redirect from EX
  logic           redirect;
  word_t          redirect_pc;

  // Dequeue side towards ID
  logic           deq_ready;
  logic           deq_valid;
  word_t          deq_pc;
  word_t          deq_pc4;
  word_t          deq_ir;
  logic [CW-1:0]  count;

  modport master (
    output imem_addr,
    input  imem_data,
    input  imem_ack_n,
    input  redirect,
    input  redirect_pc,
    input  deq_ready,
    output deq_valid,
    output deq_pc,
    output deq_pc4,
    output deq_ir,
    output count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output imem_ack_n,
    output redirect,
    output redirect_pc,
    output deq_ready,
    input  deq_valid,
    input  deq_pc,
    input  deq_pc4,
    input  deq_ir,
    input  count
  );

endinterface

// File: rtl/fetch_ring.sv
// Entry storage for the fetch queue: DEPTH x 64-bit register array with
// one synchronous write port and one asynchronous read port.
module fetch_ring
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_entry_t rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  // Write the incoming entry into its slot.
  // NOTE: the array has no reset; occupancy is tracked by the pointers and
  // count, so stale contents are never observed as valid.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: generates the fetch PC, buffers returned words
// in a circular buffer and presents the oldest one to ID. A redirect from
// EX flushes everything and restarts fetch at the (aligned) target.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  word_t          pc_q,     pc_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q,  count_d;

  logic           full;
  logic           deq_valid;
  logic           deq_fire;
  logic           enq_fire;
  fetch_entry_t   wr_entry;
  fetch_entry_t   head_entry;

  // Handshake decode; redirect suppresses both enqueue and dequeue.
  always_comb begin
    full      = (count_q == FULL_COUNT);
    deq_valid = (count_q != '0) && !bus.redirect;
    deq_fire  = deq_valid && bus.deq_ready;
    enq_fire  = !bus.imem_ack_n && !bus.redirect && (!full || deq_fire);
    wr_entry  = '{pc: pc_q, ir: bus.imem_data};
  end

  // Next-state for fetch PC, pointers and occupancy.
  // NOTE: every target gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect) begin
      pc_d     = align_pc(bus.redirect_pc);
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        pc_d     = pc_next(pc_q);
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (enq_fire && !deq_fire) begin
        count_d = count_q + 1'b1;
      end else if (deq_fire && !enq_fire) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State registers; reset clears occupancy immediately without a clock.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk     (clk),
    .we_i    (enq_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  // Head presentation; an empty slot shows a NOP rather than stale data.
  assign bus.imem_addr = pc_q;
  assign bus.deq_valid = deq_valid;
  assign bus.deq_pc    = head_entry.pc;
  assign bus.deq_pc4   = pc_next(head_entry.pc);
  assign bus.deq_ir    = deq_valid ? head_entry.ir : NOP_INSTR;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0).
// Instruction memory is modelled as data = addr ^ 32'hA5A5_0000.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fetch_queue_if #(.DEPTH(4)) bus ();

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  function automatic word_t mem_word(input word_t a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #90000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.imem_ack_n  = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.deq_ready   = 1'b0;

    // Reset state, before and across clock edges
    #2;
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", {31'b0, bus.deq_valid}, 32'h0);
    check("rst_count", {29'b0, bus.count}, 32'h0);
    step();
    step();
    check("rst_hold_addr", bus.imem_addr, 32'h0);
    check("rst_hold_count", {29'b0, bus.count}, 32'h0);

    // Fill with no dequeue: addr 4,8,12,16,16,16 and count 1,2,3,4,4,4
    rst            = 1'b0;
    bus.imem_ack_n = 1'b0;
    #1;
    check("fill_addr0", bus.imem_addr, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      step();
      check("fill_addr", bus.imem_addr, 32'(4 * ((i < 4) ? i : 4)));
      check("fill_count", {29'b0, bus.count}, 32'((i < 4) ? i : 4));
    end
    check("fill_valid", {31'b0, bus.deq_valid}, 32'h1);
    check("fill_head_pc", bus.deq_pc, 32'h0);
    check("fill_head_pc4", bus.deq_pc4, 32'h4);
    check("fill_head_ir", bus.deq_ir, mem_word(32'h0));

    // Full queue streaming: one in, one out per cycle
    bus.deq_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      check("stream_pc", bus.deq_pc, 32'(4 * k));
      check("stream_ir", bus.deq_ir, mem_word(32'(4 * k)));
      check("stream_count", {29'b0, bus.count}, 32'h4);
      step();
    end
    check("stream_end_addr", bus.imem_addr, 32'd40);
    check("stream_end_pc", bus.deq_pc, 32'd24);

    // Redirect during full-queue dequeue with a word offered
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    #1;
    check("redir_full_valid", {31'b0, bus.deq_valid}, 32'h0);
    step();
    bus.redirect  = 1'b0;
    bus.deq_ready = 1'b0;
    #1;
    check("redir_full_count", {29'b0, bus.count}, 32'h0);
    check("redir_full_addr", bus.imem_addr, 32'h0000_0200);
    check("redir_full_valid2", {31'b0, bus.deq_valid}, 32'h0);

    // Refill to three; first word reaches the head one cycle later
    step();
    check("lat_valid", {31'b0, bus.deq_valid}, 32'h1);
    check("lat_pc", bus.deq_pc, 32'h0000_0200);
    check("lat_count", {29'b0, bus.count}, 32'h1);
    step();
    step();
    check("three_count", {29'b0, bus.count}, 32'h3);
    check("three_addr", bus.imem_addr, 32'h0000_020C);

    // Redirect at count 3 to an unaligned target
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    #1;
    check("redir3_valid", {31'b0, bus.deq_valid}, 32'h0);
    step();
    bus.redirect = 1'b0;
    #1;
    check("redir3_count", {29'b0, bus.count}, 32'h0);
    check("redir3_addr", bus.imem_addr, 32'h0000_0100);
    step();
    check("redir3_head_valid", {31'b0, bus.deq_valid}, 32'h1);
    check("redir3_head_pc", bus.deq_pc, 32'h0000_0100);
    check("redir3_head_pc4", bus.deq_pc4, 32'h0000_0104);

    // ack_n pattern 0,1,1,0 from address 0 with ID always ready
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0;
    step();
    bus.redirect  = 1'b0;
    bus.deq_ready = 1'b1;
    bus.imem_ack_n = 1'b0;
    #1;
    check("ack_addr0", bus.imem_addr, 32'h0);
    check("ack_count0", {29'b0, bus.count}, 32'h0);
    step();
    check("ack_addr1", bus.imem_addr, 32'h4);
    check("ack_pc1", bus.deq_pc, 32'h0);
    check("ack_count1", {29'b0, bus.count}, 32'h1);
    bus.imem_ack_n = 1'b1;
    step();
    check("ack_addr2", bus.imem_addr, 32'h4);
    check("ack_valid2", {31'b0, bus.deq_valid}, 32'h0);
    step();
    check("ack_addr3", bus.imem_addr, 32'h4);
    check("ack_count3", {29'b0, bus.count}, 32'h0);
    bus.imem_ack_n = 1'b0;
    step();
    check("ack_addr4", bus.imem_addr, 32'h8);
    check("ack_valid4", {31'b0, bus.deq_valid}, 32'h1);
    check("ack_pc4", bus.deq_pc, 32'h4);
    check("ack_count4", {29'b0, bus.count}, 32'h1);

    // Back-to-back redirects: the last target wins
    bus.imem_ack_n  = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0300;
    step();
    check("b2b_addr1", bus.imem_addr, 32'h0000_0300);
    check("b2b_count1", {29'b0, bus.count}, 32'h0);
    bus.redirect_pc = 32'h0000_0047;
    step();
    check("b2b_addr2", bus.imem_addr, 32'h0000_0044);
    bus.redirect = 1'b0;
    #1;
    check("b2b_count2", {29'b0, bus.count}, 32'h0);

    // Asynchronous reset mid-cycle with two entries held
    bus.imem_ack_n = 1'b0;
    bus.deq_ready  = 1'b0;
    step();
    step();
    check("arst_pre_count", {29'b0, bus.count}, 32'h2);
    check("arst_pre_pc", bus.deq_pc, 32'h0000_0044);
    check("arst_pre_addr", bus.imem_addr, 32'h0000_004C);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", {29'b0, bus.count}, 32'h0);
    check("arst_valid", {31'b0, bus.deq_valid}, 32'h0);
    check("arst_addr", bus.imem_addr, 32'h0);
    #3;
    rst = 1'b0;
    #1;
    check("arst_rel_count", {29'b0, bus.count}, 32'h0);
    step();
    check("arst_first_count", {29'b0, bus.count}, 32'h1);
    check("arst_first_pc", bus.deq_pc, 32'h0);
    check("arst_first_addr", bus.imem_addr, 32'h4);

    // PC+4 wraps at the top of the address space
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    step();
    bus.redirect = 1'b0;
    #1;
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_pc", bus.deq_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", bus.deq_pc4, 32'h0);
    check("wrap_next_addr", bus.imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries; power of two, range 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port imem_addr, output, 32: instruction memory address, equal to the fetch PC register.
REQ-006 Port imem_data, input, 32: instruction word for imem_addr.
REQ-007 Port imem_ack_n, input, 1: 0 = imem_data valid this cycle, 1 = memory not ready.
REQ-008 Port redirect, input, 1: taken jump or branch resolved in EX.
REQ-009 Port redirect_pc, input, 32: target address for redirect.
REQ-010 Port deq_ready, input, 1: ID accepts an entry this cycle (no stall and no interlock).
REQ-011 Port deq_valid, output, 1: head entry present.
REQ-012 Port deq_pc / deq_pc4 / deq_ir, output, 32 each: head entry PC, PC+4 and instruction.
REQ-013 Port count, output, $clog2(DEPTH+1): number of occupied entries.

Function
REQ-014 Queue SHALL be a circular buffer with read and write pointers of width $clog2(DEPTH) that wrap modulo DEPTH.
REQ-015 Enqueue SHALL occur when imem_ack_n==0, redirect==0, and (count<DEPTH or a dequeue occurs in the same cycle).
  - Entry stored: {imem_addr, imem_data}.
  - Fetch PC advances by 4.
REQ-016 When imem_ack_n==1, or the queue is full with no dequeue, fetch PC and imem_addr SHALL hold; the offered word is discarded and refetched.
REQ-017 deq_valid SHALL equal (count!=0) && !redirect.
  - Dequeue occurs when deq_valid && deq_ready; the read pointer advances by 1.
REQ-018 deq_pc4 SHALL equal deq_pc+4, mod 2^32.
REQ-019 Latency: a word accepted in cycle N SHALL be at the head, if the queue was empty, in cycle N+1; there is no combinational bypass.
REQ-020 Throughput: with the queue non-empty and both handshakes true every cycle, one entry per cycle SHALL enter and leave; count stays constant.
REQ-021 Simultaneous enqueue and dequeue at count==DEPTH SHALL be permitted; count is unchanged.
REQ-022 Simultaneous enqueue and dequeue at count==0 SHALL NOT occur, because deq_valid==0.
REQ-023 redirect SHALL have priority over every other event. On the next edge:
  - pointers and count are cleared;
  - fetch PC = {redirect_pc[31:2], 2'b00};
  - no enqueue or dequeue takes effect in the redirect cycle.
REQ-024 Back-to-back redirects SHALL each apply; the last one wins.
REQ-025 count SHALL never exceed DEPTH nor underflow below 0.
REQ-026 Entry contents are don't-care when not valid; deq_* values SHALL be considered only when deq_valid==1.

Reset
REQ-027 While rst==1, outputs SHALL be:
  - imem_addr = RESET_PC;
  - deq_valid = 0;
  - count = 0.
REQ-028 Assertion of rst SHALL clear pointers and count immediately, with no clock, including mid-burst or during a redirect.
REQ-029 The first enqueue SHALL be possible on the first clock edge after rst falls; the storage array needs no reset.

Structure
REQ-030 Shared package fetch_pkg SHALL hold:
  - XLEN = 32;
  - INSTR_BYTES = 4;
  - NOP encoding 32'h0000_0013;
  - default RESET_PC.
REQ-031 Storage SHALL be one sub-module, fetch_ring: a DEPTH x 64-bit register array with one write port and one asynchronous read port.
REQ-032 PC generation, pointers and count SHALL reside in fetch_queue; total RTL 150-300 lines.

Verification (DEPTH=4, RESET_PC=0)
REQ-033 Reset, ack_n=0, deq_ready=0 for 6 cycles -> imem_addr 0,4,8,12,16 then holds at 16; count 1,2,3,4,4; entries PC 0..12.
REQ-034 Full queue, deq_ready=1, ack_n=0 -> count stays 4; deq_pc sequence 0,4,8,12,16,20; no word lost or duplicated.
REQ-035 count==3, redirect=1 with redirect_pc=32'h0000_0103 -> deq_valid=0 that cycle; next cycle count=0, imem_addr=32'h0000_0100; cycle after, deq_pc=32'h100 and deq_pc4=32'h104.
REQ-036 ack_n pattern 0,1,1,0 with deq_ready=1 -> imem_addr 0,4,4,4,8; deq_pc 0 then 4 with no bubble-borne duplicates.
REQ-037 rst pulsed asynchronously mid-cycle with count=2 -> count=0, deq_valid=0 and imem_addr=0 before the next clock edge.
REQ-038 Redirect on the same cycle as a full-queue dequeue with ack_n=0 -> next cycle count=0; neither the word nor the dequeue takes effect.
